// File: rtl/alu_cmd_ctrl_if.sv
// rtl/alu_cmd_ctrl_if.sv - UART rx, ALU and UART tx signal bundle for alu_cmd_ctrl
interface alu_cmd_ctrl_if #(
  parameter int WIDTH         = 8,
  parameter int ALU_FUN_WIDTH = 4
);
  logic [7:0]               i_rx_data;
  logic                     i_rx_valid;
  logic [WIDTH-1:0]         o_alu_a;
  logic [WIDTH-1:0]         o_alu_b;
  logic [ALU_FUN_WIDTH-1:0] o_alu_func;
  logic                     o_alu_en;
  logic                     i_alu_valid;
  logic [WIDTH-1:0]         i_alu_out;
  logic [7:0]               o_tx_data;
  logic                     o_tx_valid;
  logic                     i_tx_busy;
  logic                     o_busy;
  logic                     o_frame_err;
  logic                     o_overrun;

  modport master (
    input  i_rx_data, i_rx_valid, i_alu_valid, i_alu_out, i_tx_busy,
    output o_alu_a, o_alu_b, o_alu_func, o_alu_en, o_tx_data, o_tx_valid,
           o_busy, o_frame_err, o_overrun
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_alu_valid, i_alu_out, i_tx_busy,
    input  o_alu_a, o_alu_b, o_alu_func, o_alu_en, o_tx_data, o_tx_valid,
           o_busy, o_frame_err, o_overrun
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - UART frame to ALU command initiator with result serialiser
// Optional rx/ALU-wait timeout enabled by defining ALU_CMD_TIMEOUT_EN.
module alu_cmd_ctrl #(
  parameter int                         WIDTH          = 8,
  parameter int                         ALU_FUN_WIDTH  = 4,
  parameter logic [7-ALU_FUN_WIDTH:0]   HEADER         = 4'hA,
  parameter int                         TIMEOUT_CYCLES = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  alu_cmd_ctrl_if.master      bus
);
  localparam int NB = WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  if ((WIDTH % 8) != 0 || WIDTH < 8 || ALU_FUN_WIDTH > 7 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("alu_cmd_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, RX_A, RX_B, ISSUE, WAIT, TX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result;
  logic             hdr_ok, cnt_last, in_rx, tx_fire, tmo_hit;

  assign hdr_ok   = (bus.i_rx_data[7:ALU_FUN_WIDTH] == HEADER);
  assign cnt_last = (cnt == CW'(NB - 1));
  assign in_rx    = (state == RX_A) || (state == RX_B);
  assign tx_fire  = (state == TX) && !bus.i_tx_busy;

`ifdef ALU_CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;

  // A competing byte or ALU result in the expiry cycle wins over the timeout.
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) &&
                   ((in_rx && !bus.i_rx_valid) || (state == WAIT && !bus.i_alu_valid));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tmo_cnt <= '0;
    end else if (state_nxt != state || (in_rx && bus.i_rx_valid)) begin
      tmo_cnt <= '0;
    end else if (in_rx || state == WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    bus.o_alu_en   = 1'b0;
    bus.o_tx_valid = 1'b0;
    bus.o_busy     = (state != IDLE);
    bus.o_tx_data  = '0;
    for (int i = 0; i < NB; i++) begin
      if (cnt == CW'(i)) bus.o_tx_data = result[8*i +: 8];
    end
    unique case (state)
      IDLE: if (bus.i_rx_valid && hdr_ok) state_nxt = RX_A;
      RX_A: begin
        if (bus.i_rx_valid) begin
          if (cnt_last) state_nxt = RX_B;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      RX_B: begin
        if (bus.i_rx_valid) begin
          if (cnt_last) state_nxt = ISSUE;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        bus.o_alu_en = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (bus.i_alu_valid) state_nxt = TX;
        else if (tmo_hit)    state_nxt = IDLE;
      end
      TX: begin
        bus.o_tx_valid = 1'b1;
        if (tx_fire && cnt_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state           <= IDLE;
      cnt             <= '0;
      result          <= '0;
      bus.o_alu_a     <= '0;
      bus.o_alu_b     <= '0;
      bus.o_alu_func  <= '0;
      bus.o_frame_err <= 1'b0;
      bus.o_overrun   <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.o_frame_err <= (state == IDLE && bus.i_rx_valid && !hdr_ok) || tmo_hit;
      bus.o_overrun   <= bus.i_rx_valid && (state == ISSUE || state == WAIT || state == TX);

      if (state_nxt != state)                 cnt <= '0;
      else if ((in_rx && bus.i_rx_valid) || tx_fire) cnt <= cnt + 1'b1;

      if (state == IDLE && bus.i_rx_valid && hdr_ok)
        bus.o_alu_func <= bus.i_rx_data[ALU_FUN_WIDTH-1:0];
      if (state == WAIT && bus.i_alu_valid)
        result <= bus.i_alu_out;
      for (int i = 0; i < NB; i++) begin
        if (bus.i_rx_valid && cnt == CW'(i)) begin
          if (state == RX_A) bus.o_alu_a[8*i +: 8] <= bus.i_rx_data;
          if (state == RX_B) bus.o_alu_b[8*i +: 8] <= bus.i_rx_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - directed-vector bench for alu_cmd_ctrl (8- and 16-bit instances)
module tb_alu_cmd_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   en_cnt8 = 0;
  logic [7:0] tx_q8[$];
  logic [7:0] tx_q16[$];

  always #5 clk = ~clk;

  alu_cmd_ctrl_if #(.WIDTH(8),  .ALU_FUN_WIDTH(4)) if8  ();
  alu_cmd_ctrl_if #(.WIDTH(16), .ALU_FUN_WIDTH(4)) if16 ();

  alu_cmd_ctrl #(.WIDTH(8), .ALU_FUN_WIDTH(4), .HEADER(4'hA), .TIMEOUT_CYCLES(16)) dut8 (
    .i_clk(clk), .i_rst(rst_n), .bus(if8.master));
  alu_cmd_ctrl #(.WIDTH(16), .ALU_FUN_WIDTH(4), .HEADER(4'hA), .TIMEOUT_CYCLES(1024)) dut16 (
    .i_clk(clk), .i_rst(rst_n), .bus(if16.master));

  // One-cycle ALU: func 0 adds, func 1 subtracts.
  always @(posedge clk) begin
    if8.i_alu_valid  <= if8.o_alu_en;
    if8.i_alu_out    <= (if8.o_alu_func == 4'd1) ? if8.o_alu_a - if8.o_alu_b : if8.o_alu_a + if8.o_alu_b;
    if16.i_alu_valid <= if16.o_alu_en;
    if16.i_alu_out   <= (if16.o_alu_func == 4'd1) ? if16.o_alu_a - if16.o_alu_b : if16.o_alu_a + if16.o_alu_b;
  end

  always @(negedge clk) begin
    if (if8.o_alu_en) en_cnt8++;
    if (if8.o_tx_valid && !if8.i_tx_busy) tx_q8.push_back(if8.o_tx_data);
    if (if16.o_tx_valid && !if16.i_tx_busy) tx_q16.push_back(if16.o_tx_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit w16, input logic [7:0] b);
    if (w16) begin if16.i_rx_data = b; if16.i_rx_valid = 1'b1; end
    else     begin if8.i_rx_data  = b; if8.i_rx_valid  = 1'b1; end
    step();
    if16.i_rx_valid = 1'b0;
    if8.i_rx_valid  = 1'b0;
  endtask

  task automatic wait_idle(input bit w16, input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!(w16 ? if16.o_busy : if8.o_busy)) break;
      step();
    end
    check(tag, w16 ? if16.o_busy : if8.o_busy, 1'b0);
  endtask

  initial begin
    logic [7:0] held;
    bit         stable;
    if8.i_rx_data = '0;  if8.i_rx_valid = 1'b0;  if8.i_tx_busy = 1'b0;
    if16.i_rx_data = '0; if16.i_rx_valid = 1'b0; if16.i_tx_busy = 1'b0;
    step(3);
    check("rst_busy",   if8.o_busy, 1'b0);
    check("rst_txv",    if8.o_tx_valid, 1'b0);
    check("rst_a",      if8.o_alu_a, 8'h00);
    check("rst_err",    if8.o_frame_err, 1'b0);
    check("rst_busy16", if16.o_busy, 1'b0);
    rst_n = 1'b1;
    step();

    // ADD 5 + 3
    tx_q8.delete(); en_cnt8 = 0;
    send(0, 8'hA0); send(0, 8'h05); send(0, 8'h03);
    check("t1_en",   if8.o_alu_en, 1'b1);
    check("t1_a",    if8.o_alu_a, 8'h05);
    check("t1_b",    if8.o_alu_b, 8'h03);
    check("t1_func", if8.o_alu_func, 4'h0);
    step(2);
    check("t1_lat_txv", if8.o_tx_valid, 1'b1);
    check("t1_lat_txd", if8.o_tx_data, 8'h08);
    wait_idle(0, "t1_idle");
    check("t1_en_cnt", en_cnt8, 1);
    check("t1_n",      tx_q8.size(), 1);
    if (tx_q8.size() > 0) check("t1_byte", tx_q8[0], 8'h08);

    // Bad header, then SUB 9 - 4
    send(0, 8'h50);
    check("t2_err",  if8.o_frame_err, 1'b1);
    check("t2_busy", if8.o_busy, 1'b0);
    step();
    check("t2_err_pulse", if8.o_frame_err, 1'b0);
    tx_q8.delete();
    send(0, 8'hA1); send(0, 8'h09); send(0, 8'h04);
    check("t2_func", if8.o_alu_func, 4'h1);
    wait_idle(0, "t2_idle");
    check("t2_n", tx_q8.size(), 1);
    if (tx_q8.size() > 0) check("t2_byte", tx_q8[0], 8'h05);

    // Transmitter busy for 10 cycles
    tx_q8.delete();
    if8.i_tx_busy = 1'b1;
    send(0, 8'hA0); send(0, 8'h02); send(0, 8'h03);
    for (int i = 0; i < 20 && !if8.o_tx_valid; i++) step();
    held = if8.o_tx_data;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!if8.o_tx_valid || if8.o_tx_data !== held) stable = 1'b0;
      step();
    end
    check("t3_hold_data", held, 8'h05);
    check("t3_stable",    stable, 1'b1);
    check("t3_no_xfer",   tx_q8.size(), 0);
    if8.i_tx_busy = 1'b0;
    wait_idle(0, "t3_idle");
    check("t3_n", tx_q8.size(), 1);

    // 16-bit: 0x1234 + 0x0001
    tx_q16.delete();
    send(1, 8'hA0); send(1, 8'h34); send(1, 8'h12); send(1, 8'h01); send(1, 8'h00);
    check("t4_a", if16.o_alu_a, 16'h1234);
    check("t4_b", if16.o_alu_b, 16'h0001);
    wait_idle(1, "t4_idle");
    check("t4_n", tx_q16.size(), 2);
    if (tx_q16.size() == 2) begin
      check("t4_lsb", tx_q16[0], 8'h35);
      check("t4_msb", tx_q16[1], 8'h12);
    end

    // Stray byte during WAIT
    tx_q8.delete();
    send(0, 8'hA0); send(0, 8'h07); send(0, 8'h01);
    step();
    send(0, 8'hFF);
    check("t5_ovr",   if8.o_overrun, 1'b1);
    check("t5_txd",   if8.o_tx_data, 8'h08);
    wait_idle(0, "t5_idle");
    check("t5_n", tx_q8.size(), 1);
    if (tx_q8.size() > 0) check("t5_byte", tx_q8[0], 8'h08);

    // Reset while in RX_B
    send(0, 8'hA1); send(0, 8'h11);
    rst_n = 1'b0;
    #1;
    check("t6_busy", if8.o_busy, 1'b0);
    check("t6_a",    if8.o_alu_a, 8'h00);
    check("t6_func", if8.o_alu_func, 4'h0);
    check("t6_txv",  if8.o_tx_valid, 1'b0);
    step(2);
    rst_n = 1'b1;
    step();
    tx_q8.delete();
    send(0, 8'hA0); send(0, 8'h01); send(0, 8'h01);
    wait_idle(0, "t6_idle");
    check("t6_n", tx_q8.size(), 1);
    if (tx_q8.size() > 0) check("t6_byte", tx_q8[0], 8'h02);

`ifdef ALU_CMD_TIMEOUT_EN
    send(0, 8'hA0); send(0, 8'h05);
    step(15);
    check("t7_err_early", if8.o_frame_err, 1'b0);
    check("t7_busy_early", if8.o_busy, 1'b1);
    step();
    check("t7_err",  if8.o_frame_err, 1'b1);
    check("t7_busy", if8.o_busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
